im_loader: RTL and testbench

- Byte-stream program loader that writes the 15-bit instruction memory: opcode in bits [14:8], literal k8 in bits [7:0].
- Receives a framed program over a valid/ready byte interface and assembles each 15-bit word from two bytes.
- Issues one write strobe per instruction and verifies a trailing XOR checksum.
- Holds the CPU stalled (`cpu_hold`) while loading. It is the writer side of the instruction-memory read path used by the PC/IM fetch.

---
 rtl/im_loader_if.sv | 24 ++
 rtl/im_loader.sv | 141 ++++++++++++++
 tb/tb_im_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write bundle between a program source and im_loader.
// The loader sits on the slave side; the program source / bench drives the master side.
interface im_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [14:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/im_loader.sv
// Framed byte-stream loader for the 15-bit instruction memory: COUNT, N x (HI, LO), CHK.
// Keeps the CPU stalled until a frame with a matching XOR checksum has been written.
module im_loader #(
    parameter logic [7:0] BASE_ADDR     = 8'h00,
    parameter bit         HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    im_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t      state_r;
    logic [7:0]  addr_r;
    logic [8:0]  remaining_r;
    logic [7:0]  chk_r;
    logic [6:0]  hi_r;
    logic        rx_ready_r;
    logic        im_we_r;
    logic [7:0]  im_addr_r;
    logic [14:0] im_wdata_r;
    logic        cpu_hold_r;
    logic        done_r;
    logic        error_r;
    logic        accept_s;

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    assign accept_s     = bus.rx_valid & rx_ready_r;
    assign bus.rx_ready = rx_ready_r;
    assign bus.im_we    = im_we_r;
    assign bus.im_addr  = im_addr_r;
    assign bus.im_wdata = im_wdata_r;
    assign bus.cpu_hold = cpu_hold_r;
    assign bus.done     = done_r;
    assign bus.error    = error_r;

    // Frame sequencer; every output is updated together with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            addr_r      <= BASE_ADDR;
            remaining_r <= 9'd0;
            chk_r       <= 8'h00;
            hi_r        <= 7'h00;
            rx_ready_r  <= 1'b0;
            im_we_r     <= 1'b0;
            im_addr_r   <= BASE_ADDR;
            im_wdata_r  <= 15'h0000;
            cpu_hold_r  <= HOLD_AT_RESET;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_r    <= S_COUNT;
                        addr_r     <= BASE_ADDR;
                        chk_r      <= 8'h00;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                        cpu_hold_r <= 1'b1;
                        rx_ready_r <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (accept_s) begin
                        // A count of zero encodes a full 256-word image.
                        remaining_r <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                        chk_r       <= chk_fold(chk_r, bus.rx_data);
                        state_r     <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept_s) begin
                        if (bus.rx_data[7]) begin
                            state_r    <= S_ERR;
                            rx_ready_r <= 1'b0;
                            error_r    <= 1'b1;
                            cpu_hold_r <= 1'b1;
                        end else begin
                            hi_r    <= bus.rx_data[6:0];
                            chk_r   <= chk_fold(chk_r, bus.rx_data);
                            state_r <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (accept_s) begin
                        chk_r      <= chk_fold(chk_r, bus.rx_data);
                        state_r    <= S_WRITE;
                        rx_ready_r <= 1'b0;
                        im_we_r    <= 1'b1;
                        im_addr_r  <= addr_r;
                        im_wdata_r <= {hi_r, bus.rx_data};
                    end
                end
                S_WRITE: begin
                    im_we_r     <= 1'b0;
                    addr_r      <= addr_r + 8'd1;
                    remaining_r <= remaining_r - 9'd1;
                    rx_ready_r  <= 1'b1;
                    state_r     <= (remaining_r == 9'd1) ? S_CHK : S_HI;
                end
                S_CHK: begin
                    if (accept_s) begin
                        rx_ready_r <= 1'b0;
                        if (bus.rx_data == chk_r) begin
                            state_r    <= S_DONE;
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            state_r    <= S_ERR;
                            error_r    <= 1'b1;
                            cpu_hold_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    rx_ready_r <= 1'b0;
                    im_we_r    <= 1'b0;
                    cpu_hold_r <= HOLD_AT_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: two instances (base 8'h00 and 8'h10) share one byte stream.
// Writes are logged on falling edges and compared against hand-computed frames.
module tb_im_loader;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       start    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;

    int n_tests    = 0;
    int n_fail     = 0;
    int ready_viol = 0;
    int timeouts   = 0;
    int mism       = 0;

    logic [7:0]  wa_addr[$];
    logic [14:0] wa_data[$];
    logic [7:0]  wb_addr[$];
    logic [14:0] wb_data[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_addr[256];
    logic [14:0] exp_data[256];
    logic [7:0]  chk;
    logic [7:0]  hi_b;
    logic [7:0]  lo_b;

    im_loader_if ifa();
    im_loader_if ifb();

    assign ifa.start    = start;
    assign ifa.rx_valid = rx_valid;
    assign ifa.rx_data  = rx_data;
    assign ifb.start    = start;
    assign ifb.rx_valid = rx_valid;
    assign ifb.rx_data  = rx_data;

    im_loader #(.BASE_ADDR(8'h00), .HOLD_AT_RESET(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    im_loader #(.BASE_ADDR(8'h10), .HOLD_AT_RESET(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    // Write logger; a write with rx_ready high means a byte could be taken during WRITE.
    always @(negedge clk) begin
        if (ifa.im_we === 1'b1) begin
            wa_addr.push_back(ifa.im_addr);
            wa_data.push_back(ifa.im_wdata);
            if (ifa.rx_ready !== 1'b0) ready_viol++;
        end
        if (ifb.im_we === 1'b1) begin
            wb_addr.push_back(ifb.im_addr);
            wb_data.push_back(ifb.im_wdata);
            if (ifb.rx_ready !== 1'b0) ready_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (ifa.rx_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) timeouts++;
        else @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        foreach (frame_q[i]) send_byte(frame_q[i], int'($urandom_range(maxgap, 0)));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa_addr.delete();
        wa_data.delete();
        wb_addr.delete();
        wb_data.delete();
        ready_viol = 0;
        timeouts   = 0;
    endtask

    task automatic check_good(input string tag);
        check({tag, " writes"},   wa_addr.size(), 2);
        check({tag, " addr0"},    wa_addr[0], 8'h00);
        check({tag, " data0"},    wa_data[0], 15'h1234);
        check({tag, " addr1"},    wa_addr[1], 8'h01);
        check({tag, " data1"},    wa_data[1], 15'h05A0);
        check({tag, " b_addr0"},  wb_addr[0], 8'h10);
        check({tag, " done"},     ifa.done, 1'b1);
        check({tag, " error"},    ifa.error, 1'b0);
        check({tag, " cpu_hold"}, ifa.cpu_hold, 1'b0);
        check({tag, " rx_ready"}, ifa.rx_ready, 1'b0);
        check({tag, " ready_in_write"}, ready_viol, 0);
        check({tag, " timeouts"}, timeouts, 0);
    endtask

    initial begin
        // Asynchronous reset applied between clock edges.
        #12 rst = 1'b1;
        #1;
        check("rst rx_ready", ifa.rx_ready, 1'b0);
        check("rst im_we",    ifa.im_we, 1'b0);
        check("rst done",     ifa.done, 1'b0);
        check("rst error",    ifa.error, 1'b0);
        check("rst cpu_hold", ifa.cpu_hold, 1'b1);
        check("rst im_addr",  ifa.im_addr, 8'h00);
        check("rst im_wdata", ifa.im_wdata, 15'h0000);
        check("rst b_addr",   ifb.im_addr, 8'h10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle cpu_hold", ifa.cpu_hold, 1'b1);
        check("idle rx_ready", ifa.rx_ready, 1'b0);

        // Good load, N=2, no gaps.
        clear_log();
        frame_q = '{8'h02, 8'h12, 8'h34, 8'h05, 8'hA0, 8'h81};
        do_start();
        check("start rx_ready", ifa.rx_ready, 1'b1);
        check("start cpu_hold", ifa.cpu_hold, 1'b1);
        send_frame(0);
        check_good("good");

        // Same frame with random gaps on rx_valid; restart also clears done.
        clear_log();
        do_start();
        check("restart done", ifa.done, 1'b0);
        check("restart cpu_hold", ifa.cpu_hold, 1'b1);
        send_frame(3);
        check_good("bp");

        // Bad checksum.
        clear_log();
        frame_q[5] = 8'h80;
        do_start();
        send_frame(1);
        check("badchk writes",   wa_addr.size(), 2);
        check("badchk addr1",    wa_addr[1], 8'h01);
        check("badchk data1",    wa_data[1], 15'h05A0);
        check("badchk error",    ifa.error, 1'b1);
        check("badchk done",     ifa.done, 1'b0);
        check("badchk cpu_hold", ifa.cpu_hold, 1'b1);

        // Framing error on the second HI byte.
        clear_log();
        frame_q = '{8'h02, 8'h12, 8'h34, 8'h80};
        do_start();
        check("frame start error", ifa.error, 1'b0);
        send_frame(0);
        check("frame error",    ifa.error, 1'b1);
        check("frame cpu_hold", ifa.cpu_hold, 1'b1);
        check("frame rx_ready", ifa.rx_ready, 1'b0);
        repeat (4) @(negedge clk);
        check("frame writes", wa_addr.size(), 1);
        check("frame data0",  wa_data[0], 15'h1234);

        // 256-word image (count byte 0) on the base-8'h10 instance.
        frame_q.delete();
        frame_q.push_back(8'h00);
        chk = 8'h00;
        for (int i = 0; i < 256; i++) begin
            hi_b = 8'((i * 3) & 8'h7F);
            lo_b = 8'(i) ^ 8'h5A;
            frame_q.push_back(hi_b);
            frame_q.push_back(lo_b);
            chk = chk ^ hi_b ^ lo_b;
            exp_addr[i] = 8'h10 + 8'(i);
            exp_data[i] = {hi_b[6:0], lo_b};
        end
        frame_q.push_back(chk);
        clear_log();
        do_start();
        send_frame(0);
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (i >= wb_addr.size()) mism++;
            else if (wb_addr[i] !== exp_addr[i] || wb_data[i] !== exp_data[i]) mism++;
        end
        check("n256 writes",    wb_addr.size(), 256);
        check("n256 mismatches", mism, 0);
        check("n256 first addr", wb_addr[0], 8'h10);
        check("n256 addr FF",    wb_addr[239], 8'hFF);
        check("n256 wrap addr",  wb_addr[240], 8'h00);
        check("n256 last addr",  wb_addr[255], 8'h0F);
        check("n256 done",       ifb.done, 1'b1);
        check("n256 cpu_hold",   ifb.cpu_hold, 1'b0);
        check("n256 ready_in_write", ready_viol, 0);

        // Restart from DONE begins at the base address again.
        clear_log();
        do_start();
        check("rerun done",     ifb.done, 1'b0);
        check("rerun hold",     ifb.cpu_hold, 1'b1);
        check("rerun addr held", ifb.im_addr, 8'h0F);
        frame_q = '{8'h01, 8'h01, 8'h02, 8'h02};
        send_frame(2);
        check("rerun writes", wb_addr.size(), 1);
        check("rerun addr",   wb_addr[0], 8'h10);
        check("rerun data",   wb_data[0], 15'h0102);
        check("rerun done2",  ifb.done, 1'b1);

        // Reset in the middle of a load.
        clear_log();
        do_start();
        frame_q = '{8'h02, 8'h12};
        send_frame(0);
        check("midrst pre rx_ready", ifa.rx_ready, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst rx_ready", ifa.rx_ready, 1'b0);
        check("midrst cpu_hold", ifa.cpu_hold, 1'b1);
        check("midrst done",     ifa.done, 1'b0);
        check("midrst im_wdata", ifa.im_wdata, 15'h0000);
        check("midrst b_addr",   ifb.im_addr, 8'h10);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst writes", wa_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
